// File: rtl/sdram_arbiter_if.sv
// Requester and SDRAM-controller side signals of the arbiter.
// master: arbiter view; slave: requesters plus controller.
interface sdram_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]    req_read;
  logic [NUM_REQ-1:0]    req_write;
  logic [25*NUM_REQ-1:0] req_addr;
  logic [16*NUM_REQ-1:0] req_wdata;
  logic [NUM_REQ-1:0]    req_ack;
  logic [NUM_REQ-1:0]    req_rvalid;
  logic [15:0]           rdata;
  logic                  busy;
  logic                  timeout_err;
  logic                  mem_read;
  logic                  mem_write;
  logic [24:0]           mem_address;
  logic [15:0]           mem_data_in;
  logic                  mem_ready;
  logic                  mem_valid;
  logic [15:0]           mem_data_out;

  modport master (
    input  req_read, req_write,
    input  req_addr, req_wdata,
    input  mem_ready, mem_valid,
    input  mem_data_out,
    output req_ack, req_rvalid,
    output rdata, busy, timeout_err,
    output mem_read, mem_write,
    output mem_address, mem_data_in
  );

  modport slave (
    output req_read, req_write,
    output req_addr, req_wdata,
    output mem_ready, mem_valid,
    output mem_data_out,
    input  req_ack, req_rvalid,
    input  rdata, busy, timeout_err,
    input  mem_read, mem_write,
    input  mem_address, mem_data_in
  );
endinterface

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller port
// among NUM_REQ requesters, one transaction at a time.
module sdram_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 4095
) (
  input logic             clk,
  input logic             reset,
  sdram_arbiter_if.master bus
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] ISSUE     = 2'd1;
  localparam logic [1:0] WAIT_DATA = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [PW-1:0]      rr_q, rr_d;
  logic [PW-1:0]      own_q, own_d;
  logic [TW-1:0]      tmr_q, tmr_d;
  logic               cmd_rd_q, cmd_rd_d;
  logic               rd_q, rd_d;
  logic               wr_q, wr_d;
  logic [24:0]        addr_q, addr_d;
  logic [15:0]        wd_q, wd_d;
  logic [15:0]        rdata_q, rdata_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [NUM_REQ-1:0] rv_q, rv_d;
  logic               err_q, err_d;
  logic               busy_q;

  logic [NUM_REQ-1:0] elig;
  logic [24:0]        addr_a [NUM_REQ];
  logic [15:0]        wd_a [NUM_REQ];
  logic               found;
  logic [PW-1:0]      win;
  logic [PW-1:0]      cand;
  logic               expired;

  assign elig = bus.req_read ^ bus.req_write;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_sl
    assign addr_a[i] = bus.req_addr[25*i +: 25];
    assign wd_a[i]   = bus.req_wdata[16*i +: 16];
  end

  // Scan starts just after the last winner.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = PW'((int'(rr_q) + k) % NUM_REQ);
      if (!found && elig[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Also catches a late accept that pushed timer past the limit.
  assign expired = (tmr_q >= TW'(TIMEOUT - 1));

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    own_d    = own_q;
    tmr_d    = tmr_q;
    cmd_rd_d = cmd_rd_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wd_d     = wd_q;
    rdata_d  = rdata_q;
    ack_d    = '0;
    rv_d     = '0;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.mem_ready && found) begin
          rd_d       = bus.req_read[win];
          wr_d       = bus.req_write[win];
          cmd_rd_d   = bus.req_read[win];
          addr_d     = addr_a[win];
          wd_d       = wd_a[win];
          ack_d[win] = 1'b1;
          rr_d       = win;
          own_d      = win;
          tmr_d      = '0;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        tmr_d = tmr_q + 1'b1;
        if (!bus.mem_ready) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = cmd_rd_q ? WAIT_DATA : IDLE;
        end else if (expired) begin
          err_d   = 1'b1;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = IDLE;
          if (cmd_rd_q) begin
            rv_d[own_q] = 1'b1;
            rdata_d     = 16'h0000;
          end
        end
      end
      WAIT_DATA: begin
        tmr_d = tmr_q + 1'b1;
        if (bus.mem_valid) begin
          rdata_d     = bus.mem_data_out;
          rv_d[own_q] = 1'b1;
          state_d     = IDLE;
        end else if (expired) begin
          err_d       = 1'b1;
          rv_d[own_q] = 1'b1;
          rdata_d     = 16'h0000;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_q     <= PW'(NUM_REQ - 1);
      own_q    <= '0;
      tmr_q    <= '0;
      cmd_rd_q <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wd_q     <= '0;
      rdata_q  <= '0;
      ack_q    <= '0;
      rv_q     <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      own_q    <= own_d;
      tmr_q    <= tmr_d;
      cmd_rd_q <= cmd_rd_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wd_q     <= wd_d;
      rdata_q  <= rdata_d;
      ack_q    <= ack_d;
      rv_q     <= rv_d;
      err_q    <= err_d;
      busy_q   <= (state_d != IDLE);
    end
  end

  assign bus.mem_read    = rd_q;
  assign bus.mem_write   = wr_q;
  assign bus.mem_address = addr_q;
  assign bus.mem_data_in = wd_q;
  assign bus.req_ack     = ack_q;
  assign bus.req_rvalid  = rv_q;
  assign bus.rdata       = rdata_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = err_q;
endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: directed requests,
// a small controller model, and a monitor on ack/rvalid.
module tb_sdram_arbiter;
  logic clk = 1'b0;
  logic reset;

  sdram_arbiter_if #(.NUM_REQ(2)) bus ();

  sdram_arbiter #(
    .NUM_REQ(2),
    .TIMEOUT(15)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rv;
    bit          idx;
    logic [24:0] addr;
    logic [15:0] data;
    bit          rd;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_err = 0;

  logic        m_hold;
  logic        m_never;
  logic [15:0] m_rdata;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_ack(input bit i, input logic [24:0] a,
                          input logic [15:0] d, input bit rd);
    exp_t e;
    e.rv = 1'b0; e.idx = i; e.addr = a; e.data = d; e.rd = rd;
    q.push_back(e);
  endtask

  task automatic push_rv(input bit i, input logic [15:0] d);
    exp_t e;
    e.rv = 1'b1; e.idx = i; e.addr = '0; e.data = d; e.rd = 1'b1;
    q.push_back(e);
  endtask

  task automatic check_evt(input bit rv, input bit i);
    exp_t e;
    if (q.size() == 0) begin
      n_chk++;
      n_err++;
      $display("FAIL unexpected_event: rv=%0d req=%0d, none expected",
               rv, i);
      return;
    end
    e = q.pop_front();
    chk("evt_kind", 64'(rv), 64'(e.rv));
    chk("evt_idx", 64'(i), 64'(e.idx));
    if (rv) begin
      chk("rdata", 64'(bus.rdata), 64'(e.data));
    end else begin
      chk("mem_address", 64'(bus.mem_address), 64'(e.addr));
      chk("mem_data_in", 64'(bus.mem_data_in), 64'(e.data));
      chk("mem_read", 64'(bus.mem_read), 64'(e.rd));
      chk("mem_write", 64'(bus.mem_write), 64'(!e.rd));
    end
  endtask

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      if (bus.req_ack[0] === 1'b1) check_evt(1'b0, 1'b0);
      if (bus.req_ack[1] === 1'b1) check_evt(1'b0, 1'b1);
      if (bus.req_rvalid[0] === 1'b1) check_evt(1'b1, 1'b0);
      if (bus.req_rvalid[1] === 1'b1) check_evt(1'b1, 1'b1);
    end
  end

  // Controller model: drop ready 2 cycles into a command,
  // writes recover ready 2 cycles later, reads return data after 4.
  initial begin
    int  ph;
    int  cnt;
    bit  is_rd;
    ph = 0; cnt = 0; is_rd = 1'b0;
    bus.mem_ready    = 1'b1;
    bus.mem_valid    = 1'b0;
    bus.mem_data_out = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        ph = 0; cnt = 0;
        bus.mem_ready = 1'b1;
        bus.mem_valid = 1'b0;
        bus.mem_data_out = '0;
      end else if (ph == 0) begin
        bus.mem_ready = !m_hold;
        bus.mem_valid = 1'b0;
        if (!m_hold && (bus.mem_read || bus.mem_write)) begin
          ph = 1; cnt = 1; is_rd = bus.mem_read;
        end
      end else if (ph == 1) begin
        if (!(bus.mem_read || bus.mem_write)) begin
          ph = 0;
        end else begin
          cnt++;
          if (cnt >= 2 && !m_never) begin
            bus.mem_ready = 1'b0; cnt = 0; ph = 2;
          end
        end
      end else begin
        cnt++;
        if (!is_rd && cnt == 2) begin
          bus.mem_ready = 1'b1; ph = 0;
        end
        if (is_rd && cnt == 4) begin
          bus.mem_valid = 1'b1; bus.mem_data_out = m_rdata;
        end
        if (is_rd && cnt == 5) begin
          bus.mem_valid = 1'b0; bus.mem_ready = 1'b1; ph = 0;
        end
      end
    end
  end

  task automatic wait_ack(input bit i);
    int n = 0;
    while (bus.req_ack[i] !== 1'b1 && n < 300) begin
      @(negedge clk); n++;
    end
    chk("ack_seen", 64'(bus.req_ack[i]), 64'd1);
  endtask

  task automatic wait_rv(input bit i);
    int n = 0;
    while (bus.req_rvalid[i] !== 1'b1 && n < 300) begin
      @(negedge clk); n++;
    end
    chk("rvalid_seen", 64'(bus.req_rvalid[i]), 64'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy !== 1'b0 && n < 300) begin
      @(negedge clk); n++;
    end
    chk("idle", 64'(bus.busy), 64'd0);
  endtask

  task automatic settle();
    repeat (6) @(negedge clk);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_mem"}, 64'({bus.mem_read, bus.mem_write,
        bus.mem_address, bus.mem_data_in}), 64'd0);
    chk({nm, "_req"}, 64'({bus.req_ack, bus.req_rvalid, bus.rdata,
        bus.busy, bus.timeout_err}), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    int   acks;
    int   rv0;
    int   rv1;
    logic seen;
    reset = 1'b1;
    m_hold = 1'b0;
    m_never = 1'b0;
    m_rdata = '0;
    bus.req_read = '0;
    bus.req_write = '0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_zero("reset");

    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen = seen | bus.busy | (|bus.req_ack) | bus.mem_read;
    end
    chk("no_req_idle", 64'(seen), 64'd0);

    // Write from requester 0
    push_ack(1'b0, 25'h0001234, 16'hBEEF, 1'b0);
    bus.req_write[0] = 1'b1;
    bus.req_addr[24:0] = 25'h0001234;
    bus.req_wdata[15:0] = 16'hBEEF;
    wait_ack(1'b0);
    bus.req_write[0] = 1'b0;
    n = 0;
    while (bus.mem_write && n < 20) begin
      n++; @(negedge clk);
    end
    chk("wr_len", 64'(n), 64'd2);
    wait_idle();

    // Read from requester 1
    m_rdata = 16'h5A5A;
    push_ack(1'b1, 25'h1ABCDEF, 16'h0000, 1'b1);
    push_rv(1'b1, 16'h5A5A);
    bus.req_read[1] = 1'b1;
    bus.req_addr[49:25] = 25'h1ABCDEF;
    bus.req_wdata[31:16] = 16'h0000;
    wait_ack(1'b1);
    bus.req_read[1] = 1'b0;
    wait_rv(1'b1);
    wait_idle();
    settle();

    // Round robin with both reading
    m_rdata = 16'hC3C3;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) begin
        push_ack(1'b0, 25'h0000100, 16'h0000, 1'b1);
        push_rv(1'b0, 16'hC3C3);
      end else begin
        push_ack(1'b1, 25'h0000200, 16'h0000, 1'b1);
        push_rv(1'b1, 16'hC3C3);
      end
    end
    bus.req_addr = {25'h0000200, 25'h0000100};
    bus.req_wdata = '0;
    bus.req_read = 2'b11;
    acks = 0; rv0 = 0; rv1 = 0; n = 0;
    while ((acks < 4 || rv0 + rv1 < 4) && n < 400) begin
      @(negedge clk); n++;
      if (bus.req_ack[0]) acks++;
      if (bus.req_ack[1]) acks++;
      if (bus.req_rvalid[0]) rv0++;
      if (bus.req_rvalid[1]) rv1++;
      if (acks == 4) bus.req_read = 2'b00;
    end
    chk("rr_acks", 64'(acks), 64'd4);
    chk("rr_rv0", 64'(rv0), 64'd2);
    chk("rr_rv1", 64'(rv1), 64'd2);
    wait_idle();
    settle();

    // Ready held low; requester 1 illegal (read and write)
    m_hold = 1'b1;
    repeat (2) @(negedge clk);
    bus.req_addr = {25'h0000DEF, 25'h0000ABC};
    bus.req_wdata = {16'h2468, 16'h1357};
    bus.req_write = 2'b11;
    bus.req_read = 2'b10;
    seen = 1'b0;
    repeat (100) begin
      @(negedge clk);
      seen = seen | (|bus.req_ack) | bus.mem_write | bus.busy;
    end
    chk("hold_no_issue", 64'(seen), 64'd0);
    push_ack(1'b0, 25'h0000ABC, 16'h1357, 1'b0);
    m_hold = 1'b0;
    wait_ack(1'b0);
    bus.req_write[0] = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      seen = seen | bus.req_ack[1];
    end
    chk("illegal_no_ack", 64'(seen), 64'd0);
    bus.req_read = 2'b00;
    bus.req_write = 2'b00;
    wait_idle();
    settle();

    // Controller never accepts a read
    m_never = 1'b1;
    m_rdata = 16'hFFFF;
    push_ack(1'b0, 25'h0000777, 16'h0000, 1'b1);
    push_rv(1'b0, 16'h0000);
    bus.req_addr[24:0] = 25'h0000777;
    bus.req_wdata[15:0] = 16'h0000;
    bus.req_read[0] = 1'b1;
    wait_ack(1'b0);
    bus.req_read[0] = 1'b0;
    n = 0;
    while (bus.mem_read && n < 40) begin
      n++; @(negedge clk);
    end
    chk("tmo_len", 64'(n), 64'd15);
    chk("tmo_err", 64'(bus.timeout_err), 64'd1);
    m_never = 1'b0;
    wait_idle();
    settle();

    // Error stays set across a normal write
    push_ack(1'b1, 25'h0000055, 16'h00AA, 1'b0);
    bus.req_addr[49:25] = 25'h0000055;
    bus.req_wdata[31:16] = 16'h00AA;
    bus.req_write[1] = 1'b1;
    wait_ack(1'b1);
    bus.req_write[1] = 1'b0;
    wait_idle();
    settle();
    chk("tmo_sticky", 64'(bus.timeout_err), 64'd1);

    // Reset during WAIT_DATA
    m_rdata = 16'hABCD;
    push_ack(1'b0, 25'h0000999, 16'h0000, 1'b1);
    bus.req_addr[24:0] = 25'h0000999;
    bus.req_wdata[15:0] = 16'h0000;
    bus.req_read[0] = 1'b1;
    wait_ack(1'b0);
    bus.req_read[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("wait_busy", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    chk_zero("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk_zero("post_reset");

    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
Round-robin arbiter that shares the single-port SDRAM controller among NUM_REQ requesters (e.g. frame buffer, CPU, DMA).
- One transaction outstanding at a time.
- Sequences the controller's read/write/ready/valid handshake, routes read data back to the owning requester, and flags a hung controller via timeout.
- Sits between requester logic and the controller's user interface.

Parameters:
NUM_REQ, 2, number of requesters (2..4).
TIMEOUT, 4095, max cycles spent in ISSUE or WAIT_DATA before abort.

Ports:
clk  in  1  system clock (also clocks the controller).
reset  in  1  synchronous, active-high reset.
req_read  in  NUM_REQ  per-requester read request; hold until ack.
req_write  in  NUM_REQ  per-requester write request; hold until ack.
req_addr  in  25*NUM_REQ  word address, requester i at [25i+24:25i].
req_wdata  in  16*NUM_REQ  write data, requester i at [16i+15:16i].
req_ack  out  NUM_REQ  one-cycle pulse: request accepted; requester may change inputs next cycle.
req_rvalid  out  NUM_REQ  one-cycle pulse: rdata valid for requester i.
rdata  out  16  registered read data, shared.
busy  out  1  transaction in flight (state != IDLE).
timeout_err  out  1  sticky; cleared only by reset.
mem_read  out  1  to controller read.
mem_write  out  1  to controller write.
mem_address  out  25  to controller address.
mem_data_in  out  16  to controller data_in.
mem_ready  in  1  from controller ready.
mem_valid  in  1  from controller valid.
mem_data_out  in  16  from controller data_out.

Behaviour:
- All outputs are registered.
- Reset values:
  - mem_read=0, mem_write=0, mem_address=0, mem_data_in=0.
  - req_ack=0, req_rvalid=0, rdata=0, busy=0, timeout_err=0.
  - state=IDLE, rr_ptr=NUM_REQ-1 (requester 0 wins first).
- Eligibility: requester i is eligible iff req_read[i] XOR req_write[i]. Both set is illegal; that requester is skipped, never acked.
- IDLE:
  - In a cycle with mem_ready=1 and at least one eligible requester, select the winner W: first eligible index scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ.
  - Next cycle: mem_read=req_read[W], mem_write=req_write[W], mem_address/mem_data_in = W's slices, req_ack[W]=1 (single pulse), rr_ptr=W, owner=W, timer=0, state=ISSUE.
  - With mem_ready=0 (init, refresh, recovery), nothing is issued; requests wait.
- ISSUE:
  - Hold command, address and data stable.
  - On the first cycle mem_ready samples 0 (controller accepted), deassert mem_read/mem_write next cycle.
  - Then go to WAIT_DATA if the command was a read, else IDLE.
- WAIT_DATA:
  - On mem_valid=1: rdata<=mem_data_out and req_rvalid[owner]=1 for one cycle; state=IDLE in the same update.
  - mem_valid outside WAIT_DATA is ignored.
- Timeout (ISSUE and WAIT_DATA only):
  - timer increments each cycle. If timer reaches TIMEOUT, then timeout_err<=1 and mem_read/mem_write<=0.
  - If in WAIT_DATA or the command was a read: req_rvalid[owner] pulses with rdata=16'h0000.
  - state=IDLE.
- Stale ready: after a write returns to IDLE, mem_ready is still low, so the IDLE rule blocks re-issue until the controller raises ready again. No extra state is needed.
- Fairness: a continuously requesting requester waits at most NUM_REQ-1 transactions.
- Requester inputs are sampled only in the IDLE grant cycle. Changes while not granted are allowed.
- Reset mid-transaction: return to reset values on the next edge. The in-flight requester gets no rvalid, and the controller is reset by the same line.

Test Plan:
- Reset, then no requests with mem_ready=1 -> all outputs 0, busy=0 indefinitely.
- Req0 writes addr 25'h0001234, data 16'hBEEF; model raises ready and drops it 2 cycles after write -> mem_write=1 with those values for exactly 2 cycles, req_ack[0] one pulse, no req_rvalid, busy returns 0.
- Req1 reads addr 25'h1ABCDEF; model returns valid with 16'h5A5A 4 cycles after accept -> rdata=16'h5A5A, req_rvalid[1] pulses once, req_rvalid[0] stays 0.
- Both requesters hold reads continuously for 4 transactions -> grant order 0,1,0,1; each receives exactly 2 rvalid pulses.
- mem_ready held 0 for 100 cycles while req0 writes -> no mem_write, no ack until ready rises, then normal issue. Req with both read and write set -> never acked.
- Model never drops ready after a read, TIMEOUT=15 -> abort 15 cycles after issue, timeout_err=1 sticky, req_rvalid pulse with rdata=0. Assert reset in WAIT_DATA of another read -> all outputs 0 next cycle and timeout_err cleared.
